// File: rtl/spi_drum_code_poll_master.sv
// SPI mode-0 polling master for the drum-code slave: clocks one byte per frame,
// checks that the upper nibble is zero and reports the code as a single-cycle pulse.
module spi_drum_code_poll_master #(
   parameter int unsigned CLK_DIV  = 3,
   parameter int unsigned CS_SETUP = 2,
   parameter int unsigned POLL_GAP = 16,
   parameter logic [7:0]  TX_CMD   = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   output logic       sck,
   output logic       cs_n,
   output logic       mosi,
   input  logic       miso,
   output logic [7:0] rx_byte,
   output logic [3:0] drum_code,
   output logic       code_valid,
   output logic       frame_error,
   output logic       busy
);

   localparam int HALF_W  = $clog2(CLK_DIV + 1);
   localparam int SETUP_W = $clog2(CS_SETUP + 1);
   localparam int GAP_W   = $clog2(POLL_GAP + 1);

   localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(CLK_DIV - 1);
   localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(CS_SETUP - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(POLL_GAP - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t             state;
   logic [HALF_W-1:0]  half_cnt;
   logic [SETUP_W-1:0] setup_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift_reg;
   logic [6:0]         tx_shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         half_cnt    <= '0;
         setup_cnt   <= '0;
         gap_cnt     <= '0;
         bit_cnt     <= 3'd0;
         shift_reg   <= 8'h00;
         tx_shift    <= 7'h00;
         sck         <= 1'b0;
         cs_n        <= 1'b1;
         mosi        <= 1'b0;
         rx_byte     <= 8'h00;
         drum_code   <= 4'h0;
         code_valid  <= 1'b0;
         frame_error <= 1'b0;
         busy        <= 1'b0;
      end else begin
         code_valid  <= 1'b0;
         frame_error <= 1'b0;
         case (state)
            IDLE: begin
               if (enable) begin
                  state     <= SETUP;
                  busy      <= 1'b1;
                  cs_n      <= 1'b0;
                  mosi      <= TX_CMD[7];
                  tx_shift  <= TX_CMD[6:0];
                  bit_cnt   <= 3'd0;
                  setup_cnt <= '0;
               end
            end

            SETUP: begin
               if (setup_cnt == SETUP_LAST) begin
                  setup_cnt <= '0;
                  half_cnt  <= '0;
                  state     <= SHIFT;
               end else begin
                  setup_cnt <= setup_cnt + 1'b1;
               end
            end

            // Each bit: CLK_DIV cycles low, then CLK_DIV cycles high.
            SHIFT: begin
               if (half_cnt == HALF_LAST) begin
                  half_cnt <= '0;
                  if (!sck) begin
                     sck       <= 1'b1;
                     shift_reg <= {shift_reg[6:0], miso};
                  end else begin
                     sck <= 1'b0;
                     if (bit_cnt == 3'd7) begin
                        state <= HOLD;
                     end else begin
                        mosi     <= tx_shift[6];
                        tx_shift <= {tx_shift[5:0], 1'b0};
                        bit_cnt  <= bit_cnt + 3'd1;
                     end
                  end
               end else begin
                  half_cnt <= half_cnt + 1'b1;
               end
            end

            HOLD: begin
               if (half_cnt == HALF_LAST) begin
                  half_cnt <= '0;
                  cs_n     <= 1'b1;
                  mosi     <= 1'b0;
                  rx_byte  <= shift_reg;
                  if (shift_reg[7:4] == 4'h0) begin
                     code_valid <= 1'b1;
                     drum_code  <= shift_reg[3:0];
                  end else begin
                     frame_error <= 1'b1;
                  end
                  gap_cnt <= '0;
                  state   <= GAP;
               end else begin
                  half_cnt <= half_cnt + 1'b1;
               end
            end

            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cs_n  <= 1'b1;
               sck   <= 1'b0;
               mosi  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_drum_code_poll_master.sv
// Bench for spi_drum_code_poll_master: slave model, table of single frames,
// plus sequences for back-to-back timing, mid-frame reset and enable drop.
module tb_spi_drum_code_poll_master;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       sck;
   logic       cs_n;
   logic       mosi;
   logic       miso = 1'b0;
   logic [7:0] rx_byte;
   logic [3:0] drum_code;
   logic       code_valid;
   logic       frame_error;
   logic       busy;

   int checks = 0;
   int errors = 0;

   spi_drum_code_poll_master #(
      .CLK_DIV (3),
      .CS_SETUP(2),
      .POLL_GAP(16),
      .TX_CMD  (8'h81)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .sck        (sck),
      .cs_n       (cs_n),
      .mosi       (mosi),
      .miso       (miso),
      .rx_byte    (rx_byte),
      .drum_code  (drum_code),
      .code_valid (code_valid),
      .frame_error(frame_error),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Slave model: first bit on cs_n fall, next bit after each sck fall.
   logic [7:0] slave_byte = 8'h00;
   logic [7:0] slv_sr = 8'h00;
   int         cs_fall_cnt = 0;
   always @(negedge cs_n) begin
      cs_fall_cnt++;
      slv_sr = slave_byte;
      miso   = slv_sr[7];
   end
   always @(negedge sck) begin
      if (!cs_n) begin
         slv_sr = {slv_sr[6:0], 1'b0};
         miso   = slv_sr[7];
      end
   end

   // Bus monitors
   int         sck_rises = 0;
   int         bad_period = 0;
   int         last_rise_frame = -1;
   time        last_rise_t = 0;
   logic [7:0] mosi_bits = 8'h00;
   always @(posedge sck) begin
      if (last_rise_frame == cs_fall_cnt && ($time - last_rise_t) != 60) bad_period++;
      last_rise_frame = cs_fall_cnt;
      last_rise_t     = $time;
      sck_rises++;
      mosi_bits = {mosi_bits[6:0], mosi};
   end

   int n_valid = 0, n_err = 0, sck_bad = 0;
   int lo_run = 0, hi_run = 0, last_low = 0, last_gap = 0;
   always @(negedge clk) begin
      if (code_valid) n_valid++;
      if (frame_error) n_err++;
      if (sck && cs_n) sck_bad++;
      if (cs_n) begin
         if (lo_run != 0) last_low = lo_run;
         lo_run = 0;
         hi_run++;
      end else begin
         if (hi_run != 0) last_gap = hi_run;
         hi_run = 0;
         lo_run++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cs_low(input string name);
      int n = 0;
      while (cs_n && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(name, cs_n, 1'b0);
   endtask

   task automatic wait_busy_low(input string name);
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(name, busy, 1'b0);
   endtask

   task automatic wait_rises(input int base, input int cnt, input string name);
      int n = 0;
      while ((sck_rises - base) < cnt && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(name, sck_rises - base, cnt);
   endtask

   typedef struct {
      logic [7:0] slv;
      logic [7:0] exp_rx;
      logic [3:0] exp_code;
      int         exp_valid;
      int         exp_err;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int v0, e0, r0, f0;

      vecs[0] = '{8'h02, 8'h02, 4'h2, 1, 0};
      vecs[1] = '{8'hA5, 8'hA5, 4'h2, 0, 1};
      vecs[2] = '{8'h0F, 8'h0F, 4'hF, 1, 0};
      vecs[3] = '{8'h0F, 8'h0F, 4'hF, 1, 0};
      vecs[4] = '{8'h10, 8'h10, 4'hF, 0, 1};
      vecs[5] = '{8'h00, 8'h00, 4'h0, 1, 0};
      vecs[6] = '{8'hF7, 8'hF7, 4'h0, 0, 1};

      rst_n  = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sck", sck, 1'b0);
      chk("rst_cs_n", cs_n, 1'b1);
      chk("rst_mosi", mosi, 1'b0);
      chk("rst_rx_byte", rx_byte, 8'h00);
      chk("rst_drum_code", drum_code, 4'h0);
      chk("rst_code_valid", code_valid, 1'b0);
      chk("rst_frame_error", frame_error, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single frames from the table
      for (int i = 0; i < 7; i++) begin
         v0 = n_valid;
         e0 = n_err;
         r0 = sck_rises;
         slave_byte = vecs[i].slv;
         enable = 1'b1;
         wait_cs_low("frame_start");
         enable = 1'b0;
         wait_busy_low("frame_done");
         $display("frame %0d slave=%02h rx=%02h code=%0h valid=%0d err=%0d", i, vecs[i].slv,
                  rx_byte, drum_code, n_valid - v0, n_err - e0);
         chk("rx_byte", rx_byte, vecs[i].exp_rx);
         chk("drum_code", drum_code, vecs[i].exp_code);
         chk("code_valid_pulses", n_valid - v0, vecs[i].exp_valid);
         chk("frame_error_pulses", n_err - e0, vecs[i].exp_err);
         chk("sck_rises", sck_rises - r0, 8);
         chk("cs_low_len", last_low, 53);
         chk("mosi_bits", mosi_bits, 8'h81);
      end

      // Back-to-back polling: gap of POLL_GAP+1 cycles
      v0 = n_valid;
      slave_byte = 8'h03;
      enable = 1'b1;
      wait_cs_low("b2b_first");
      @(negedge clk);
      wait_busy_low("b2b_first_done");
      wait_cs_low("b2b_second");
      @(negedge clk);
      enable = 1'b0;
      chk("gap_len", last_gap, 17);
      wait_busy_low("b2b_done");
      $display("b2b gap=%0d valid=%0d code=%0h", last_gap, n_valid - v0, drum_code);
      chk("b2b_valid_pulses", n_valid - v0, 2);
      chk("b2b_code", drum_code, 4'h3);

      // Reset after the 4th sck rise
      v0 = n_valid;
      e0 = n_err;
      r0 = sck_rises;
      slave_byte = 8'h07;
      enable = 1'b1;
      wait_cs_low("rst_frame_start");
      wait_rises(r0, 4, "rst_4_rises");
      rst_n = 1'b0;
      #1;
      $display("midframe reset cs_n=%0b sck=%0b busy=%0b", cs_n, sck, busy);
      chk("midrst_cs_n", cs_n, 1'b1);
      chk("midrst_sck", sck, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      repeat (2) @(negedge clk);
      chk("midrst_no_pulse", (n_valid - v0) + (n_err - e0), 0);
      chk("midrst_code_cleared", drum_code, 4'h0);
      rst_n = 1'b1;
      wait_cs_low("post_rst_start");
      enable = 1'b0;
      wait_busy_low("post_rst_done");
      $display("post reset frame rx=%02h code=%0h", rx_byte, drum_code);
      chk("post_rst_code", drum_code, 4'h7);
      chk("post_rst_valid", n_valid - v0, 1);

      // Enable dropped during SHIFT
      v0 = n_valid;
      r0 = sck_rises;
      slave_byte = 8'h09;
      enable = 1'b1;
      wait_cs_low("drop_start");
      wait_rises(r0, 2, "drop_in_shift");
      enable = 1'b0;
      wait_busy_low("drop_done");
      chk("drop_valid", n_valid - v0, 1);
      chk("drop_code", drum_code, 4'h9);
      f0 = cs_fall_cnt;
      repeat (40) @(negedge clk);
      $display("parked cs_n=%0b busy=%0b new_frames=%0d", cs_n, busy, cs_fall_cnt - f0);
      chk("parked_no_frames", cs_fall_cnt - f0, 0);
      chk("parked_busy", busy, 1'b0);
      enable = 1'b1;
      wait_cs_low("resume");
      enable = 1'b0;
      wait_busy_low("resume_done");
      chk("resume_code", drum_code, 4'h9);

      chk("sck_high_with_cs_high", sck_bad, 0);
      chk("sck_period", bad_period, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
